// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: shared constants for the keypad operand-entry block.
//   - key codes (digits are 0-9; KEY_ADD..KEY_CLR below)
//   - BLANK digit code shown on the display echo for unentered positions
//   - opcode encodings presented to the ALU stage
//   - entry FSM state type
package operand_entry_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_ENT = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam logic [3:0] BLANK   = 4'hE;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

  function automatic logic [1:0] key2op(input logic [3:0] code);
    logic [1:0] op;
    case (code)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      default: op = OP_DIV;
    endcase
    return op;
  endfunction

  // Display echo for one operand: tens shown only with two digits entered,
  // units shown once at least one digit is entered.
  function automatic logic [7:0] echo(input logic [1:0] cnt,
                                      input logic [3:0] tens,
                                      input logic [3:0] units);
    return {(cnt >= 2'd2) ? tens  : BLANK,
            (cnt >= 2'd1) ? units : BLANK};
  endfunction

endpackage

// File: rtl/operand_entry_bcd2bin.sv
// bcd2bin: converts a two-digit BCD value (tens, units) to 7-bit binary.
//   iTENS  in  4  tens digit, 0-9
//   iUNITS in  4  units digit, 0-9
//   oBIN   out 7  tens*10 + units, 0-99
module bcd2bin (
  input  logic [3:0] iTENS,
  input  logic [3:0] iUNITS,
  output logic [6:0] oBIN
);

  logic [6:0] tens7;
  logic [6:0] units7;

  assign tens7  = {3'b000, iTENS};
  assign units7 = {3'b000, iUNITS};

  // tens*10 as shift-and-add: (t<<3) + (t<<1)
  assign oBIN = (tens7 << 3) + (tens7 << 1) + units7;

endmodule

// File: rtl/operand_entry.sv
// operand_entry: keypad front end for the calculator datapath. Collects
// digit/operator key events, assembles operands A and B (0-99) and an opcode,
// and presents them to the ALU stage over a valid/ready handshake.
//   iCLK        in  1   clock
//   iRST        in  1   synchronous active-high reset
//   iKEY_VALID  in  1   key event strobe
//   iKEY_CODE   in  4   0-9 digit, A add, B sub, C mul, D div, E enter, F clear
//   iREADY      in  1   ALU stage accepts the request
//   oVALID      out 1   oA/oB/oOP hold a complete request
//   oA, oB      out 7   operands, binary
//   oOP         out 2   opcode 00 add, 01 sub, 10 mul, 11 div
//   oDISP       out 16  {A tens, A units, B tens, B units} BCD, 4'hE = blank
//   oERR        out 1   one-cycle pulse when an enter is rejected
// Configuration macro: OPERAND_ENTRY_DIVZ_CHECK_EN rejects enter on divide by
// zero (state stays S_B, oERR pulses); undefined, oERR is tied low.
module operand_entry
  import operand_entry_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iKEY_VALID,
  input  logic [3:0]  iKEY_CODE,
  input  logic        iREADY,
  output logic        oVALID,
  output logic [6:0]  oA,
  output logic [6:0]  oB,
  output logic [1:0]  oOP,
  output logic [15:0] oDISP,
  output logic        oERR
);

  state_e      state_q, state_d;
  logic [3:0]  a_tens_q, a_tens_d, a_units_q, a_units_d;
  logic [3:0]  b_tens_q, b_tens_d, b_units_q, b_units_d;
  logic [1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [1:0]  op_q, op_d;
  logic        valid_q, valid_d;
  logic [6:0]  a_q, b_q, a_bin_d, b_bin_d;
  logic [15:0] disp_q, disp_d;
  logic        key_clr;
`ifdef OPERAND_ENTRY_DIVZ_CHECK_EN
  logic        err_q, err_d;
`endif

  assign key_clr = iKEY_VALID && (iKEY_CODE == KEY_CLR);

  always_comb begin
    state_d   = state_q;
    a_tens_d  = a_tens_q;
    a_units_d = a_units_q;
    b_tens_d  = b_tens_q;
    b_units_d = b_units_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    op_d      = op_q;
`ifdef OPERAND_ENTRY_DIVZ_CHECK_EN
    err_d     = 1'b0;
`endif
    // Clear and a completed transfer both end in the same cleared S_A state,
    // so clear-with-ready needs no separate priority handling.
    if (key_clr || (valid_q && iREADY)) begin
      state_d   = S_A;
      a_tens_d  = '0;
      a_units_d = '0;
      b_tens_d  = '0;
      b_units_d = '0;
      a_cnt_d   = '0;
      b_cnt_d   = '0;
      op_d      = OP_ADD;
    end else if (iKEY_VALID) begin
      case (state_q)
        S_A: begin
          if (is_digit(iKEY_CODE)) begin
            if (a_cnt_q < 2'd2) begin
              a_tens_d  = a_units_q;
              a_units_d = iKEY_CODE;
              a_cnt_d   = a_cnt_q + 2'd1;
            end
          end else if (is_op(iKEY_CODE)) begin
            op_d    = key2op(iKEY_CODE);
            state_d = S_B;
          end
        end
        S_B: begin
          if (is_digit(iKEY_CODE)) begin
            if (b_cnt_q < 2'd2) begin
              b_tens_d  = b_units_q;
              b_units_d = iKEY_CODE;
              b_cnt_d   = b_cnt_q + 2'd1;
            end
          end else if (is_op(iKEY_CODE)) begin
            op_d = key2op(iKEY_CODE);
          end else if (iKEY_CODE == KEY_ENT) begin
`ifdef OPERAND_ENTRY_DIVZ_CHECK_EN
            if ((op_q == OP_DIV) && (b_tens_q == 4'd0) && (b_units_q == 4'd0))
              err_d = 1'b1;
            else
              state_d = S_HOLD;
`else
            state_d = S_HOLD;
`endif
          end
        end
        default: ;
      endcase
    end
    valid_d = (state_d == S_HOLD);
    disp_d  = {echo(a_cnt_d, a_tens_d, a_units_d),
               echo(b_cnt_d, b_tens_d, b_units_d)};
  end

  // Converters operate on next-state digits so oA/oB are registered values.
  bcd2bin u_bcd2bin_a (
    .iTENS  (a_tens_d),
    .iUNITS (a_units_d),
    .oBIN   (a_bin_d)
  );

  bcd2bin u_bcd2bin_b (
    .iTENS  (b_tens_d),
    .iUNITS (b_units_d),
    .oBIN   (b_bin_d)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= S_A;
      a_tens_q  <= '0;
      a_units_q <= '0;
      b_tens_q  <= '0;
      b_units_q <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      op_q      <= OP_ADD;
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      disp_q    <= {4{BLANK}};
`ifdef OPERAND_ENTRY_DIVZ_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_tens_q  <= a_tens_d;
      a_units_q <= a_units_d;
      b_tens_q  <= b_tens_d;
      b_units_q <= b_units_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      a_q       <= a_bin_d;
      b_q       <= b_bin_d;
      disp_q    <= disp_d;
`ifdef OPERAND_ENTRY_DIVZ_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign oVALID = valid_q;
  assign oA     = a_q;
  assign oB     = b_q;
  assign oOP    = op_q;
  assign oDISP  = disp_q;
`ifdef OPERAND_ENTRY_DIVZ_CHECK_EN
  assign oERR   = err_q;
`else
  assign oERR   = 1'b0;
`endif

endmodule

// File: tb/tb_operand_entry.sv
// Testbench for operand_entry: table of per-cycle vectors with expected
// outputs after each clock edge, plus a hand-written hold/stability sequence.
module tb_operand_entry;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iKEY_VALID = 1'b0;
  logic [3:0]  iKEY_CODE = 4'h0;
  logic        iREADY = 1'b0;
  logic        oVALID;
  logic [6:0]  oA, oB;
  logic [1:0]  oOP;
  logic [15:0] oDISP;
  logic        oERR;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  operand_entry dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iKEY_VALID (iKEY_VALID),
    .iKEY_CODE  (iKEY_CODE),
    .iREADY     (iREADY),
    .oVALID     (oVALID),
    .oA         (oA),
    .oB         (oB),
    .oOP        (oOP),
    .oDISP      (oDISP),
    .oERR       (oERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        rst;
    logic        kv;
    logic [3:0]  key;
    logic        rdy;
    logic        ev;
    logic [6:0]  ea;
    logic [6:0]  eb;
    logic [1:0]  eop;
    logic [15:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic kv, input logic [3:0] key,
                     input logic rdy, input logic ev, input logic [6:0] ea,
                     input logic [6:0] eb, input logic [1:0] eop,
                     input logic [15:0] ed, input logic ee);
    vec_t t;
    t.rst = rst; t.kv = kv; t.key = key; t.rdy = rdy;
    t.ev = ev; t.ea = ea; t.eb = eb; t.eop = eop; t.ed = ed; t.ee = ee;
    tbl.push_back(t);
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, sample at the
  // next falling edge.
  task automatic step(input logic rst, input logic kv, input logic [3:0] key,
                      input logic rdy);
    iRST = rst; iKEY_VALID = kv; iKEY_CODE = key; iREADY = rdy;
    @(negedge iCLK);
  endtask

  task automatic check(input string name, input int idx, input vec_t t);
    n_vec++;
    if (oVALID !== t.ev || oA !== t.ea || oB !== t.eb || oOP !== t.eop ||
        oDISP !== t.ed || oERR !== t.ee) begin
      n_bad++;
      $display("FAIL %s[%0d]: got valid=%0b a=%0d b=%0d op=%0d disp=%h err=%0b, want valid=%0b a=%0d b=%0d op=%0d disp=%h err=%0b",
               name, idx, oVALID, oA, oB, oOP, oDISP, oERR,
               t.ev, t.ea, t.eb, t.eop, t.ed, t.ee);
    end
  endtask

  localparam logic [15:0] BL = 16'hEEEE;

  initial begin
    vec_t h;
    // reset, then enter in S_A is ignored
    add(1,0,4'h0,0, 0, 0, 0,0,BL,0);
    add(0,1,4'hE,0, 0, 0, 0,0,BL,0);
    // 4,2,add,1,7,enter; hold 3 cycles; ready
    add(0,1,4'h4,0, 0, 4, 0,0,16'hE4EE,0);
    add(0,1,4'h2,0, 0,42, 0,0,16'h42EE,0);
    add(0,1,4'hA,0, 0,42, 0,0,16'h42EE,0);
    add(0,1,4'h1,0, 0,42, 1,0,16'h42E1,0);
    add(0,1,4'h7,0, 0,42,17,0,16'h4217,0);
    add(0,1,4'hE,0, 1,42,17,0,16'h4217,0);
    add(0,0,4'h0,0, 1,42,17,0,16'h4217,0);
    add(0,0,4'h0,0, 1,42,17,0,16'h4217,0);
    add(0,0,4'h0,1, 0, 0, 0,0,BL,0);
    // 9,9,9,mul,5,enter; ready high while idle is ignored
    add(0,1,4'h9,1, 0, 9, 0,0,16'hE9EE,0);
    add(0,1,4'h9,0, 0,99, 0,0,16'h99EE,0);
    add(0,1,4'h9,0, 0,99, 0,0,16'h99EE,0);
    add(0,1,4'hC,0, 0,99, 0,2,16'h99EE,0);
    add(0,1,4'h5,0, 0,99, 5,2,16'h99E5,0);
    add(0,1,4'hE,0, 1,99, 5,2,16'h99E5,0);
    add(0,0,4'h0,1, 0, 0, 0,0,BL,0);
    // sub,enter with no digits
    add(0,1,4'hB,0, 0, 0, 0,1,BL,0);
    add(0,1,4'hE,0, 1, 0, 0,1,BL,0);
    add(0,0,4'h0,1, 0, 0, 0,0,BL,0);
    // 8,div,0,enter
    add(0,1,4'h8,0, 0, 8, 0,0,16'hE8EE,0);
    add(0,1,4'hD,0, 0, 8, 0,3,16'hE8EE,0);
    add(0,1,4'h0,0, 0, 8, 0,3,16'hE8E0,0);
`ifdef OPERAND_ENTRY_DIVZ_CHECK_EN
    add(0,1,4'hE,0, 0, 8, 0,3,16'hE8E0,1);
    add(0,1,4'h3,0, 0, 8, 3,3,16'hE803,0);
    add(0,1,4'hE,0, 1, 8, 3,3,16'hE803,0);
`else
    add(0,1,4'hE,0, 1, 8, 0,3,16'hE8E0,0);
`endif
    add(0,0,4'h0,1, 0, 0, 0,0,BL,0);
    // 6,add,sub (op replaced),2,enter; key in HOLD ignored; clear with ready
    add(0,1,4'h6,0, 0, 6, 0,0,16'hE6EE,0);
    add(0,1,4'hA,0, 0, 6, 0,0,16'hE6EE,0);
    add(0,1,4'hB,0, 0, 6, 0,1,16'hE6EE,0);
    add(0,1,4'h2,0, 0, 6, 2,1,16'hE6E2,0);
    add(0,1,4'hE,0, 1, 6, 2,1,16'hE6E2,0);
    add(0,1,4'h7,0, 1, 6, 2,1,16'hE6E2,0);
    add(0,1,4'hF,1, 0, 0, 0,0,BL,0);
    // 5,add,3 then reset; 1,add,1,enter
    add(0,1,4'h5,0, 0, 5, 0,0,16'hE5EE,0);
    add(0,1,4'hA,0, 0, 5, 0,0,16'hE5EE,0);
    add(0,1,4'h3,0, 0, 5, 3,0,16'hE5E3,0);
    add(1,0,4'h0,0, 0, 0, 0,0,BL,0);
    add(0,1,4'h1,0, 0, 1, 0,0,16'hE1EE,0);
    add(0,1,4'hA,0, 0, 1, 0,0,16'hE1EE,0);
    add(0,1,4'h1,0, 0, 1, 1,0,16'hE1E1,0);
    add(0,1,4'hE,0, 1, 1, 1,0,16'hE1E1,0);
    // reset mid-HOLD drops valid without ready
    add(1,0,4'h0,0, 0, 0, 0,0,BL,0);

    @(negedge iCLK);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].kv, tbl[i].key, tbl[i].rdy);
      check("tbl", i, tbl[i]);
    end

    // Hand sequence: 3,mul,4,enter then a long stall, outputs must stay put.
    step(0,1,4'h3,0);
    step(0,1,4'hC,0);
    step(0,1,4'h4,0);
    step(0,1,4'hE,0);
    h.rst = 0; h.kv = 0; h.key = 0; h.rdy = 0;
    h.ev = 1; h.ea = 3; h.eb = 4; h.eop = 2; h.ed = 16'hE3E4; h.ee = 0;
    check("hold_enter", 0, h);
    for (int k = 0; k < 4; k++) begin
      step(0,0,4'h0,0);
      check("hold_stall", k, h);
    end
    step(0,0,4'h0,1);
    h.ev = 0; h.ea = 0; h.eb = 0; h.eop = 0; h.ed = BL;
    check("hold_xfer", 0, h);
    step(0,0,4'h0,1);
    check("idle_ready", 0, h);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Sequential keypad front end for the calculator datapath: it collects decimal digit and operator key events one at a time, assembles two operands (0–99) and an opcode, and presents them to the ALU stage over a valid/ready handshake. It is the input-side counterpart of the binary-to-digit display path. It converts serial BCD digit entry into 7-bit binary operands and echoes the digits being entered for the seven-segment decoders.

## Interface
Parameters:
- none (key codes, opcodes and states are fixed in the package)

Ports:
- iCLK  in  1  system clock; the only clock
- iRST  in  1  reset, synchronous, active-high
- iKEY_VALID  in  1  one-cycle pulse; iKEY_CODE is valid in that cycle
- iKEY_CODE  in  4  key code: 0–9 digit; 4'hA add, 4'hB sub, 4'hC mul, 4'hD div, 4'hE enter, 4'hF clear
- iREADY  in  1  ALU stage accepts the operands
- oVALID  out  1  oA/oB/oOP hold a complete request
- oA  out  7  operand A, binary, 0–99
- oB  out  7  operand B, binary, 0–99
- oOP  out  2  opcode: 00 add, 01 sub, 10 mul, 11 div
- oDISP  out  16  echo {A tens, A units, B tens, B units} as BCD; 4'hE marks a blank digit
- oERR  out  1  one-cycle pulse when an enter key is rejected

## Operation
- States are S_A (entering A), S_B (entering B) and S_HOLD (request presented).
- Reset and clear both go to S_A. They zero all digits, digit counts and oOP. oDISP becomes 16'hEEEE, with oVALID=0 and oERR=0.
- Digit key in S_A or S_B:
  - Shifts into the active operand as new units; the old units move to tens.
  - Accepted only while the operand's digit count is below 2. A third digit is ignored, so operands saturate at two digits.
- Op key:
  - In S_A, latches oOP and moves to S_B. If no A digit was entered, A is 0.
  - In S_B, replaces oOP and stays in S_B.
- Enter key:
  - In S_B, moves to S_HOLD. Missing B digits count as 0.
  - In S_A, it is ignored.
- Conversion: value = tens*10 + units = (t<<3)+(t<<1)+u. The result is 7 bits wide and cannot exceed 99.
- Blank display: unentered digit positions show 4'hE in oDISP. An operand with one digit shows tens blank.
- S_HOLD:
  - All digit, op and enter keys are ignored; clear is still honoured.
  - On oVALID && iREADY, the block returns to S_A and clears all entries.
- Simultaneous clear and iREADY in the same cycle: clear takes precedence. The end state is identical (S_A, cleared).

## Timing
- An enter key in cycle N gives oVALID=1 and stable oA/oB/oOP from cycle N+1.
- oA, oB and oOP are registered. They must not change while oVALID=1 and iREADY=0.
- A transfer occurs on a rising edge where oVALID=1 and iREADY=1. In the next cycle oVALID=0 and oDISP=16'hEEEE.
- iREADY is ignored while oVALID=0.
- oDISP updates in the cycle after the key pulse.
- oERR is high for exactly one cycle, the cycle after the rejected enter.
- At most one key is processed per cycle. Back-to-back key pulses on consecutive cycles must all be handled.
- A clear or reset in any state, including mid-HOLD, drops oVALID on the next edge. Clear does not wait for iREADY.

## Configuration
- OPERAND_ENTRY_DIVZ_CHECK_EN defined:
  - Enter in S_B with oOP=11 and B=0 is rejected.
  - The state stays S_B and oERR pulses; the user can type B digits or clear.
- Undefined:
  - That enter is accepted as normal and oERR is tied to 0.
  - Divide-by-zero handling is left to the downstream stage.

## Structure
- Package operand_entry_pkg holds:
  - the key code constants (KEY_ADD … KEY_CLR) and the blank code 4'hE;
  - the opcode constants;
  - the state enum {S_A, S_B, S_HOLD}.
- Sub-module bcd2bin (4-bit tens, 4-bit units → 7-bit binary) is instantiated twice, once per operand.
- The FSM, digit registers and handshake live in the top module.

## Test plan
- Keys 4,2,add,1,7,enter, then iREADY=1 after 3 cycles → oA=42, oB=17, oOP=00. oVALID stays high and stable for 3 cycles, then drops, and oDISP=16'hEEEE.
- Keys 9,9,9,mul,5,enter → third 9 ignored; oA=99, oB=5, oOP=10; oDISP=16'h99E5 before enter.
- Keys sub,enter with no digits → oA=0, oB=0, oOP=01, oVALID=1 one cycle after enter.
- Keys 8,div,0,enter → with macro: oERR pulse, no oVALID, state S_B. Then 3,enter → oB=3, oVALID=1. Without macro: oVALID=1 with oB=0 and oERR=0.
- In S_HOLD with iREADY=0: key 7 ignored with oA unchanged. Clear asserted the same cycle as iREADY=1 → next cycle oVALID=0, oDISP=16'hEEEE.
- Reset asserted mid-entry (after 5,add,3) → all outputs at reset values. Then keys 1,add,1,enter → oA=1, oB=1.
